// File: rtl/clk_div_gen_if.sv
// clk_div_gen_if: run/load control and tick/clock status bundle for clk_div_gen
interface clk_div_gen_if #(
    parameter int CNT_W  = 16,
    parameter int TICK_W = 32
);
    logic              en;
    logic              div_load;
    logic [CNT_W-1:0]  div_in;
    logic              div_ack;
    logic              div_err;
    logic              tick;
    logic              clk_out;
    logic [TICK_W-1:0] tick_count;
    logic              running;

    modport master (
        output en, div_load, div_in,
        input  div_ack, div_err, tick, clk_out, tick_count, running
    );

    modport slave (
        input  en, div_load, div_in,
        output div_ack, div_err, tick, clk_out, tick_count, running
    );
endinterface

// File: rtl/clk_div_gen.sv
// clk_div_gen: programmable divide-by-N tick and near-50% divided clock with
// glitch-free divisor reload at period boundaries
module clk_div_gen #(
    parameter int CNT_W       = 16,
    parameter int TICK_W      = 32,
    parameter int DEFAULT_DIV = 2
) (
    input  logic         clk,
    input  logic         reset,
    clk_div_gen_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t            r_state, w_state;
    logic [CNT_W-1:0]  r_cnt, w_cnt, r_div, w_div, r_shadow, w_shadow, w_lshadow;
    logic              r_pending, w_pending, w_lpending;
    logic              r_tick, w_tick, r_clk, w_clk, r_ack, w_ack, r_err, w_err;
    logic [TICK_W-1:0] r_tc, w_tc;
    logic              w_ok, w_wrap;
    logic [CNT_W:0]    w_half;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_div     <= CNT_W'(DEFAULT_DIV);
            r_shadow  <= CNT_W'(DEFAULT_DIV);
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
            r_clk     <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_tc      <= '0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_div     <= w_div;
            r_shadow  <= w_shadow;
            r_pending <= w_pending;
            r_tick    <= w_tick;
            r_clk     <= w_clk;
            r_ack     <= w_ack;
            r_err     <= w_err;
            r_tc      <= w_tc;
        end
    end

    // A load landing on the wrap or exit edge is folded into that same boundary
    always_comb begin
        w_ok       = bus.div_load && bus.div_in >= CNT_W'(2);
        w_lshadow  = w_ok ? bus.div_in : r_shadow;
        w_lpending = r_pending || w_ok;
        w_wrap     = r_cnt == r_div - CNT_W'(1);
        w_state    = r_state;
        w_cnt      = '0;
        w_div      = r_div;
        w_shadow   = r_shadow;
        w_pending  = r_pending;
        w_tick     = 1'b0;
        w_tc       = r_tc;
        w_ack      = 1'b0;
        w_err      = bus.div_load && !w_ok;
        if (r_state == IDLE) begin
            w_state = bus.en ? RUN : IDLE;
            w_div   = w_ok ? bus.div_in : r_div;
            w_ack   = w_ok;
        end else if (!bus.en || w_wrap) begin
            w_state   = bus.en ? RUN : IDLE;
            w_div     = w_lpending ? w_lshadow : r_div;
            w_shadow  = w_lshadow;
            w_pending = 1'b0;
            w_ack     = w_lpending;
            w_tick    = bus.en;
            w_tc      = r_tc + TICK_W'(bus.en);
        end else begin
            w_cnt     = r_cnt + CNT_W'(1);
            w_shadow  = w_lshadow;
            w_pending = w_lpending;
        end
        w_half = ({1'b0, w_div} + (CNT_W+1)'(1)) >> 1;
        w_clk  = w_state == RUN && {1'b0, w_cnt} < w_half;
    end

    assign bus.tick       = r_tick;
    assign bus.clk_out    = r_clk;
    assign bus.div_ack    = r_ack;
    assign bus.div_err    = r_err;
    assign bus.tick_count = r_tc;
    assign bus.running    = r_state == RUN;
endmodule
